// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared constants and helpers for the reg_pipe register pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one pipeline stage (valid bit plus data register).
// Latency: 1 cycle from up_valid/up_data to vld/data when adv is high.
// Backpressure: holds its contents while adv is low; clr drops the valid bit.
// Ports: clk, rst (sync, active-high), clr (flush valid), adv (stage may load),
//        up_valid/up_data (upstream word), vld/data (registered stage contents).
// Build option DATA_RST_EN: when defined, rst also loads data with RESET_VALUE.
module reg_pipe_stage #(
  parameter int WIDTH = 8
`ifdef DATA_RST_EN
  ,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv) begin
      vld_d  = up_valid;
      data_d = up_data;
    end
    // Flush only clears the valid bit; the data register may keep stale contents.
    if (clr) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

`ifdef DATA_RST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end
`else
  // No data reset: the valid bit alone qualifies the word.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end
`endif

  assign vld  = vld_q;
  assign data = data_q;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse and flush.
// Latency: word accepted at edge N is on out_valid after edge N+DEPTH-1 (no stalls).
// Backpressure: combinational ready chain; in_ready falls only when every stage is full and out_ready is low.
// Ports: clk, rst (sync, active-high), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, occupancy (count of valid stages).
// Build option DATA_RST_EN: when defined, rst also loads every data register with RESET_VALUE.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               DEPTH       = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [occ_width(DEPTH)-1:0] occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_vld;
  logic [WIDTH-1:0] dat    [DEPTH];
  logic [WIDTH-1:0] up_dat [DEPTH];

  // Ready ripples from the output back to stage 0 so an empty stage anywhere
  // lets everything upstream of it advance (bubble collapse).
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = !vld[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = !vld[i] || rdy[i+1];
    end
  end

  assign in_ready = rdy[0] && !flush;

  always_comb begin
    up_vld    = '0;
    up_vld[0] = in_valid && in_ready;
    up_dat[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i] = vld[i-1];
      up_dat[i] = dat[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    reg_pipe_stage #(
      .WIDTH(WIDTH)
`ifdef DATA_RST_EN
      ,
      .RESET_VALUE(RESET_VALUE)
`endif
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .adv      (rdy[g]),
      .up_valid (up_vld[g]),
      .up_data  (up_dat[g]),
      .vld      (vld[g]),
      .data     (dat[g])
    );
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

  // Popcount of registered valid bits only, so occupancy has no input-to-output path.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(vld[i]);
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed stimulus with a queue scoreboard for reg_pipe (WIDTH=8, DEPTH=4).
// Latency: n/a (testbench).
// Backpressure: consumer ready is driven per directed vector.
module tb_reg_pipe;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  logic [7:0] sb_q [$];

  reg_pipe #(
    .WIDTH(8),
    .DEPTH(4),
    .RESET_VALUE(8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the falling edge; directed checks follow 1 unit later.
  task automatic drive(input bit r, input bit fl, input bit v, input logic [7:0] d, input bit ordy);
    @(negedge clk);
    #1;
    rst       = r;
    flush     = fl;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Scoreboard monitor: looks at the handshakes the next rising edge will act on.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got 0x%0h, expected no output at %0t", out_data, $time);
        end else begin
          check("sb_data", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
        end
      end
      // Words still in flight are discarded by flush; the beat leaving now is not.
      if (flush) begin
        sb_q.delete();
      end else if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // ---------------- reset ----------------
    drive(1, 0, 0, 8'h00, 0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_occ", {29'h0, occupancy}, 32'd0);
    drive(0, 0, 0, 8'h00, 0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("rst_occ2", {29'h0, occupancy}, 32'd0);
`ifdef DATA_RST_EN
    check("rst_out_data", {24'h0, out_data}, 32'h0000_00A5);
`endif

    // ---------------- streaming 0x01..0x10 ----------------
    // Word k is accepted at edge k-1 and presented in window k+3.
    for (int c = 0; c <= 20; c++) begin
      drive(0, 0, c < 16, 8'(c + 1), 1);
      if (c < 16) check("strm_in_ready", {31'h0, in_ready}, 32'd1);
      check("strm_out_valid", {31'h0, out_valid}, {31'h0, (c >= 4 && c <= 19)});
      if (c >= 4 && c <= 19) check("strm_out_data", {24'h0, out_data}, 32'(c - 3));
      check("strm_occ", {29'h0, occupancy}, 32'(((c < 16) ? c : 16) - ((c > 4) ? c - 4 : 0)));
    end

    // ---------------- backpressure ----------------
    for (int c = 0; c <= 5; c++) begin
      drive(0, 0, 1, 8'(c + 1), 0);
      check("bp_occ", {29'h0, occupancy}, 32'((c < 4) ? c : 4));
      check("bp_in_ready", {31'h0, in_ready}, {31'h0, (c < 4)});
      check("bp_out_valid", {31'h0, out_valid}, {31'h0, (c >= 4)});
      if (c >= 4) check("bp_hold_data", {24'h0, out_data}, 32'h01);
    end
    for (int c = 6; c <= 10; c++) begin
      drive(0, 0, 0, 8'h00, 1);
      check("bp_drain_valid", {31'h0, out_valid}, {31'h0, (c <= 9)});
      if (c <= 9) check("bp_drain_data", {24'h0, out_data}, 32'(c - 5));
      check("bp_drain_occ", {29'h0, occupancy}, 32'((c <= 9) ? 10 - c : 0));
    end

    // ---------------- bubble collapse ----------------
    drive(0, 0, 1, 8'hA0, 0);
    for (int c = 1; c <= 3; c++) drive(0, 0, 0, 8'h00, 0);
    drive(0, 0, 1, 8'hB0, 0);
    check("bub_out_data", {24'h0, out_data}, 32'hA0);
    drive(0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 0);
    check("bub_occ", {29'h0, occupancy}, 32'd2);
    check("bub_out_valid", {31'h0, out_valid}, 32'd1);
    check("bub_out_data2", {24'h0, out_data}, 32'hA0);
    check("bub_in_ready", {31'h0, in_ready}, 32'd1);
    drive(0, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 1);
    check("bub_second", {24'h0, out_data}, 32'hB0);
    drive(0, 0, 0, 8'h00, 1);
    check("bub_empty", {29'h0, occupancy}, 32'd0);

    // ---------------- flush ----------------
    drive(0, 0, 1, 8'h31, 0);
    drive(0, 0, 1, 8'h32, 0);
    drive(0, 0, 1, 8'h33, 0);
    drive(0, 0, 0, 8'h00, 0);
    check("fl_pre_valid", {31'h0, out_valid}, 32'd0);
    drive(0, 1, 1, 8'h3F, 1);
    check("fl_pre_occ", {29'h0, occupancy}, 32'd3);
    check("fl_in_ready", {31'h0, in_ready}, 32'd0);
    check("fl_out_valid", {31'h0, out_valid}, 32'd1);
    check("fl_out_data", {24'h0, out_data}, 32'h31);
    drive(0, 0, 0, 8'h00, 1);
    check("fl_occ", {29'h0, occupancy}, 32'd0);
    check("fl_post_valid", {31'h0, out_valid}, 32'd0);

    // ---------------- reset mid-stream ----------------
    for (int c = 0; c <= 3; c++) drive(0, 0, 1, 8'(8'h41 + c), 0);
    drive(1, 0, 0, 8'h00, 0);
    check("mr_full_occ", {29'h0, occupancy}, 32'd4);
    drive(0, 0, 0, 8'h00, 0);
    check("mr_out_valid", {31'h0, out_valid}, 32'd0);
    check("mr_occ", {29'h0, occupancy}, 32'd0);
    check("mr_in_ready", {31'h0, in_ready}, 32'd1);
    for (int c = 0; c <= 3; c++) drive(0, 0, 1, 8'(8'h51 + c), 1);
    for (int c = 0; c <= 5; c++) drive(0, 0, 0, 8'h00, 1);

    // ---------------- end of run ----------------
    drive(0, 0, 0, 8'h00, 0);
    #3;
    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    // 16 streamed + 4 backpressure + 2 bubble + 1 flush beat + 4 after reset.
    check("sb_out_count", 32'(n_out), 32'd27);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised multi-stage register pipeline, the generalised form of the team's single D flip-flop. It carries a WIDTH-bit word through DEPTH register stages with valid/ready flow control, per-stage bubble collapsing, synchronous flush and an occupancy count. It sits between any producer/consumer pair that needs timing isolation or fixed retiming latency with backpressure.

## Interface
- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 4, number of register stages (>= 1)
- RESET_VALUE, 0, value loaded into data registers on reset (used only with DATA_RST_EN)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous clear of all stage valids
- in_valid  in  1  producer word valid
- in_ready  out  1  pipeline accepts word this cycle
- in_data  in  WIDTH  producer word
- out_valid  out  1  last stage holds a word
- out_ready  in  1  consumer accepts word this cycle
- out_data  out  WIDTH  last stage word
- occupancy  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stages 0..DEPTH-1, each with a valid bit vld[i] and a data register d[i]. Stage 0 is fed by the input; stage DEPTH-1 drives the outputs.
- Stage ready: rdy[DEPTH-1] = !vld[DEPTH-1] || out_ready. For i < DEPTH-1: rdy[i] = !vld[i] || rdy[i+1]. This is a combinational chain.
- in_ready = rdy[0] && !flush.
- On each clock with rdy[i] high:
  - Stage 0 loads in_data, and vld[0] <= in_valid && in_ready.
  - Stage i > 0 loads d[i-1], and vld[i] <= vld[i-1].
- A stage with rdy[i] low holds its valid bit and data.
- Bubble collapse: a full stage advances into an empty downstream stage even when the output is stalled.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- out_valid = vld[DEPTH-1]; out_data = d[DEPTH-1].
- occupancy is the popcount of vld[], derived from registered state only.
- Data registers update only when their stage advances. Words are never duplicated, dropped or reordered, except by flush.

## Timing
- Reset, cycle after rst high: all vld = 0, out_valid = 0, occupancy = 0. in_ready = 1 once rst is low.
- rst has priority over flush, and flush has priority over an input transfer.
- Latency: a word accepted at edge N is presented on out_valid after edge N+DEPTH-1 if no stalls occur. It is therefore visible DEPTH-1 cycles after the accepting edge, since the accepting edge loads stage 0.
- Throughput: 1 word/cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, out_data is stable. Upstream stages keep filling until every stage is valid; in_ready then falls in the same cycle (combinational).
- Full pipeline with out_ready high: in_ready is high. Simultaneous output and input transfer keeps occupancy unchanged.
- flush cycle:
  - in_ready = 0.
  - An output transfer in that cycle still completes, and the consumer takes out_data.
  - All vld clear at the edge; occupancy = 0 next cycle.
  - Data registers keep stale contents.
- rst mid-stream: in-flight words are discarded. There is no partial output beat; out_valid drops at the next edge.
- DEPTH=1: single stage, latency 0 cycles after the accepting edge. Full throughput is still possible because rdy[0] includes out_ready.

## Configuration
- DATA_RST_EN defined: rst also loads every d[i] with RESET_VALUE, and out_data = RESET_VALUE after reset.
- DATA_RST_EN undefined: only the vld bits are reset. Data registers have no reset, which frees flops for area and timing, and out_data is undefined until the first word arrives.
- In both cases out_data is only meaningful while out_valid = 1.

## Structure
- Shared package reg_pipe_pkg:
  - default WIDTH/DEPTH constants
  - occupancy width function (clog2 of DEPTH+1)
- Sub-module reg_pipe_stage holds one stage:
  - the valid bit, data register and DATA_RST_EN-guarded reset
  - inputs: up_valid, up_data, adv
  - outputs: vld and data
- The top-level generates DEPTH reg_pipe_stage instances and builds the rdy chain and the occupancy popcount.

## Test plan
- Reset: after rst, out_valid=0, occupancy=0, in_ready=1. With DATA_RST_EN and RESET_VALUE=8'hA5, out_data=8'hA5.
- Streaming (DEPTH=4, WIDTH=8): feed 0x01..0x10 back-to-back with out_ready=1 -> first word appears 3 cycles after acceptance, then one word per cycle in order with no gaps.
- Backpressure: out_ready=0 while feeding -> occupancy climbs to 4, in_ready drops in the cycle occupancy reaches 4, out_data holds 0x01. Releasing out_ready drains 0x01..0x04 in order.
- Bubble collapse: load one word, stall the output, then feed a second word -> both reach stages 3 and 2 (occupancy=2). No word is lost when out_ready=1.
- Flush: with occupancy=3 and out_ready=1, assert flush together with in_valid -> the output beat completes, the input is not accepted (in_ready=0), and occupancy=0 next cycle.
- Reset mid-stream: assert rst while full and stalled -> next cycle out_valid=0, occupancy=0. A following stream is delivered intact.
